// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, loader and memory-port signals around imem_arbiter.
// The arbiter uses the slave view; the processor/loader/memory side uses master.
interface imem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [31:0]       fetch_pc;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_inst;
    logic              cpu_stall;
    logic              cpu_restart;
    logic              load_start;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic [31:0]       load_sum;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_pc, load_start, load_valid, load_addr,
               load_data, load_last, mem_rdata,
        output fetch_valid, fetch_inst, cpu_stall, cpu_restart, load_ready,
               load_sum, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_pc, load_start, load_valid, load_addr,
               load_data, load_last, mem_rdata,
        input  fetch_valid, fetch_inst, cpu_stall, cpu_restart, load_ready,
               load_sum, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between CPU fetch and a program loader.
// Define IMEM_LOAD_CHECKSUM_EN to build the rotate-XOR session checksum on load_sum.
module imem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_arbiter_if.slave bus
);
    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_LOAD    = 2'd2;
    localparam logic [1:0] S_RESTART = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_fetch_valid;
    logic              r_oor;
    logic              w_fetch_acc;
    logic              w_pc_oor;
    logic              w_beat;
    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_fetch_acc = (r_state == S_RUN) && bus.fetch_req;
    assign w_pc_oor    = |bus.fetch_pc[31:ADDR_W];
    assign w_beat      = (r_state == S_LOAD) && bus.load_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:     if (bus.load_start) w_state_next = S_DRAIN;
            S_DRAIN:   w_state_next = S_LOAD;
            S_LOAD:    if (w_beat && bus.load_last) w_state_next = S_RESTART;
            default:   w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_fetch_valid <= 1'b0;
            r_oor         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_valid <= w_fetch_acc;
            r_oor         <= w_fetch_acc && w_pc_oor;
        end
    end

    // Loader beats and fetches never overlap: beats only exist in LOAD, fetches only in RUN.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_beat) begin
            w_mem_en    = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = bus.load_addr;
            w_mem_wdata = bus.load_data;
        end else if (w_fetch_acc && !w_pc_oor) begin
            w_mem_en   = 1'b1;
            w_mem_addr = bus.fetch_pc[ADDR_W-1:0];
        end
    end

    assign bus.mem_en      = w_mem_en;
    assign bus.mem_we      = w_mem_we;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_inst  = (r_fetch_valid && !r_oor) ? bus.mem_rdata : '0;
    assign bus.cpu_stall   = (r_state != S_RUN);
    assign bus.cpu_restart = (r_state == S_RESTART);
    assign bus.load_ready  = (r_state == S_LOAD);

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if ((r_state == S_RUN) && bus.load_start) begin
            r_sum <= '0;
        end else if (w_beat) begin
            r_sum <= {r_sum[30:0], r_sum[31]} ^ 32'(bus.load_data);
        end
    end

    assign bus.load_sum = r_sum;
`else
    assign bus.load_sum = '0;
`endif
endmodule
